// File: rtl/fthread_pkg.sv
// Shared widths and helpers for the fthread TX path.
// Header/data widths match the io_requester TX port.
package fthread_pkg;

    localparam int RD_HDR_W = 71;
    localparam int WR_HDR_W = 75;
    localparam int DATA_W   = 512;
    localparam int CNT_W    = 8;

    // Width of a requester index; never narrower than one bit.
    function automatic int req_id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fthread_tx_arbiter_if.sv
// Bundle of requester-side and io_requester-side TX signals.
// The arbiter takes the slave modport; the requester/io_requester side takes the master modport.
interface fthread_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import fthread_pkg::*;

    localparam int IDW = req_id_w(NUM_REQ);

    logic [NUM_REQ-1:0]          req_en;
    logic [NUM_REQ-1:0]          in_rd_valid;
    logic [NUM_REQ-1:0]          in_rd_ready;
    logic [NUM_REQ*RD_HDR_W-1:0] in_rd_hdr;
    logic [NUM_REQ-1:0]          in_wr_valid;
    logic [NUM_REQ-1:0]          in_wr_ready;
    logic [NUM_REQ*WR_HDR_W-1:0] in_wr_hdr;
    logic [NUM_REQ*DATA_W-1:0]   in_wr_data;
    logic [NUM_REQ-1:0]          rd_rsp_done;

    logic                        cor_tx_rd_valid;
    logic                        cor_tx_rd_ready;
    logic [RD_HDR_W-1:0]         cor_tx_rd_hdr;
    logic [IDW-1:0]              cor_tx_rd_id;
    logic                        cor_tx_wr_valid;
    logic                        cor_tx_wr_ready;
    logic [WR_HDR_W-1:0]         cor_tx_wr_hdr;
    logic [DATA_W-1:0]           cor_tx_data;

    logic [NUM_REQ*CNT_W-1:0]    rd_outst;

    modport slave (
        input  req_en,
        input  in_rd_valid,
        output in_rd_ready,
        input  in_rd_hdr,
        input  in_wr_valid,
        output in_wr_ready,
        input  in_wr_hdr,
        input  in_wr_data,
        input  rd_rsp_done,
        output cor_tx_rd_valid,
        input  cor_tx_rd_ready,
        output cor_tx_rd_hdr,
        output cor_tx_rd_id,
        output cor_tx_wr_valid,
        input  cor_tx_wr_ready,
        output cor_tx_wr_hdr,
        output cor_tx_data,
        output rd_outst
    );

    modport master (
        output req_en,
        output in_rd_valid,
        input  in_rd_ready,
        output in_rd_hdr,
        output in_wr_valid,
        input  in_wr_ready,
        output in_wr_hdr,
        output in_wr_data,
        output rd_rsp_done,
        input  cor_tx_rd_valid,
        output cor_tx_rd_ready,
        input  cor_tx_rd_hdr,
        input  cor_tx_rd_id,
        input  cor_tx_wr_valid,
        output cor_tx_wr_ready,
        input  cor_tx_wr_hdr,
        input  cor_tx_data,
        input  rd_outst
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins.
// The pointer moves past the winner only when the caller accepts the grant.
module rr_arbiter
    import fthread_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = req_id_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_id_o,
    output logic          any_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] gid_s;
    logic          found_s;
    int            idx_s;

    // Search from the pointer, wrapping, and keep the first hit.
    always_comb begin
        gid_s   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < N; k++) begin
            idx_s   = (int'(ptr_q) + k) % N;
            gid_s   = (req_i[idx_s] && !found_s) ? IW'(idx_s) : gid_s;
            found_s = found_s | req_i[idx_s];
        end
    end

    // Next pointer: one past the accepted winner, otherwise unchanged.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found_s) begin
            ptr_d = (gid_s == IW'(N - 1)) ? '0 : gid_s + IW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_o    = found_s ? (N'(1) << gid_s) : '0;
    assign grant_id_o = gid_s;
    assign any_o      = found_s;

endmodule

// File: rtl/fthread_tx_arbiter.sv
// Shares one io_requester TX port pair among NUM_REQ fthread requesters with
// independent RD/WR round-robin, a one-beat output slot per channel and read credit limits.
module fthread_tx_arbiter
    import fthread_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_RD_OUTST = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    fthread_tx_arbiter_if.slave tx_if
);

    localparam int                IDW      = req_id_w(NUM_REQ);
    localparam logic [CNT_W-1:0]  RD_LIMIT = CNT_W'(MAX_RD_OUTST);

    logic [NUM_REQ-1:0]  rd_elig_s;
    logic [NUM_REQ-1:0]  wr_elig_s;
    logic [NUM_REQ-1:0]  rd_grant_s;
    logic [NUM_REQ-1:0]  wr_grant_s;
    logic [NUM_REQ-1:0]  rd_acc_s;
    logic [NUM_REQ-1:0]  wr_acc_s;
    logic [NUM_REQ-1:0]  rd_dec_s;
    logic [IDW-1:0]      rd_gid_s;
    logic [IDW-1:0]      wr_gid_s;
    logic                rd_any_s;
    logic                wr_any_s;
    logic                rd_load_s;
    logic                wr_load_s;
    logic                rd_take_s;
    logic                wr_take_s;

    logic                rd_valid_q;
    logic                rd_valid_d;
    logic [RD_HDR_W-1:0] rd_hdr_q;
    logic [RD_HDR_W-1:0] rd_hdr_d;
    logic [IDW-1:0]      rd_id_q;
    logic [IDW-1:0]      rd_id_d;
    logic                wr_valid_q;
    logic                wr_valid_d;
    logic [WR_HDR_W-1:0] wr_hdr_q;
    logic [WR_HDR_W-1:0] wr_hdr_d;
    logic [DATA_W-1:0]   wr_data_q;
    logic [DATA_W-1:0]   wr_data_d;

    logic [CNT_W-1:0]    rd_outst_q [NUM_REQ];
    logic [CNT_W-1:0]    rd_outst_d [NUM_REQ];

    // A slot may take a new beat when empty or when its beat leaves this cycle.
    assign rd_load_s = !rd_valid_q || tx_if.cor_tx_rd_ready;
    assign wr_load_s = !wr_valid_q || tx_if.cor_tx_wr_ready;
    assign rd_take_s = rd_load_s & rst_n;
    assign wr_take_s = wr_load_s & rst_n;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign rd_elig_s[g] = tx_if.in_rd_valid[g] & tx_if.req_en[g] & (rd_outst_q[g] < RD_LIMIT);
        assign wr_elig_s[g] = tx_if.in_wr_valid[g] & tx_if.req_en[g];
        assign rd_dec_s[g]  = tx_if.rd_rsp_done[g] & (rd_outst_q[g] != {CNT_W{1'b0}});
        assign tx_if.rd_outst[CNT_W*g +: CNT_W] = rd_outst_q[g];
    end

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (rd_elig_s),
        .advance_i  (rd_take_s),
        .grant_o    (rd_grant_s),
        .grant_id_o (rd_gid_s),
        .any_o      (rd_any_s)
    );

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (wr_elig_s),
        .advance_i  (wr_take_s),
        .grant_o    (wr_grant_s),
        .grant_id_o (wr_gid_s),
        .any_o      (wr_any_s)
    );

    assign rd_acc_s          = rd_grant_s & {NUM_REQ{rd_take_s}};
    assign wr_acc_s          = wr_grant_s & {NUM_REQ{wr_take_s}};
    assign tx_if.in_rd_ready = rd_acc_s;
    assign tx_if.in_wr_ready = wr_acc_s;

    // RD slot next state: capture the granted header and owner.
    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_hdr_d   = rd_hdr_q;
        rd_id_d    = rd_id_q;
        if (rd_load_s) begin
            rd_valid_d = rd_any_s;
            if (rd_any_s) begin
                rd_hdr_d = tx_if.in_rd_hdr[RD_HDR_W*int'(rd_gid_s) +: RD_HDR_W];
                rd_id_d  = rd_gid_s;
            end else begin
                rd_hdr_d = rd_hdr_q;
                rd_id_d  = rd_id_q;
            end
        end else begin
            rd_valid_d = rd_valid_q;
        end
    end

    // WR slot next state: capture the granted header and data word.
    always_comb begin
        wr_valid_d = wr_valid_q;
        wr_hdr_d   = wr_hdr_q;
        wr_data_d  = wr_data_q;
        if (wr_load_s) begin
            wr_valid_d = wr_any_s;
            if (wr_any_s) begin
                wr_hdr_d  = tx_if.in_wr_hdr[WR_HDR_W*int'(wr_gid_s) +: WR_HDR_W];
                wr_data_d = tx_if.in_wr_data[DATA_W*int'(wr_gid_s) +: DATA_W];
            end else begin
                wr_hdr_d  = wr_hdr_q;
                wr_data_d = wr_data_q;
            end
        end else begin
            wr_valid_d = wr_valid_q;
        end
    end

    // Credit counters: accept and return in the same cycle cancel out.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            case ({rd_acc_s[i], rd_dec_s[i]})
                2'b10:   rd_outst_d[i] = rd_outst_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   rd_outst_d[i] = rd_outst_q[i] - {{(CNT_W-1){1'b0}}, 1'b1};
                default: rd_outst_d[i] = rd_outst_q[i];
            endcase
        end
    end

    // Output slot registers; a reset drops any beat in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_hdr_q   <= '0;
            rd_id_q    <= '0;
            wr_valid_q <= 1'b0;
            wr_hdr_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_hdr_q   <= rd_hdr_d;
            rd_id_q    <= rd_id_d;
            wr_valid_q <= wr_valid_d;
            wr_hdr_q   <= wr_hdr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Credit counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rd_outst_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rd_outst_q[i] <= rd_outst_d[i];
            end
        end
    end

    assign tx_if.cor_tx_rd_valid = rd_valid_q;
    assign tx_if.cor_tx_rd_hdr   = rd_hdr_q;
    assign tx_if.cor_tx_rd_id    = rd_id_q;
    assign tx_if.cor_tx_wr_valid = wr_valid_q;
    assign tx_if.cor_tx_wr_hdr   = wr_hdr_q;
    assign tx_if.cor_tx_data     = wr_data_q;

endmodule

// File: tb/tb_fthread_tx_arbiter.sv
// Bench for fthread_tx_arbiter: two instances (credit limit 16 and 2) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_fthread_tx_arbiter;
    import fthread_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]          req_en, rd_valid, wr_valid, rsp_done;
    logic [N*RD_HDR_W-1:0] rd_hdr;
    logic [N*WR_HDR_W-1:0] wr_hdr;
    logic [N*DATA_W-1:0]   wr_data;
    logic                  rd_dn, wr_dn;

    fthread_tx_arbiter_if #(.NUM_REQ(N)) bus_a ();
    fthread_tx_arbiter_if #(.NUM_REQ(N)) bus_b ();

    assign bus_a.req_en = req_en;      assign bus_b.req_en = req_en;
    assign bus_a.in_rd_valid = rd_valid; assign bus_b.in_rd_valid = rd_valid;
    assign bus_a.in_rd_hdr = rd_hdr;   assign bus_b.in_rd_hdr = rd_hdr;
    assign bus_a.in_wr_valid = wr_valid; assign bus_b.in_wr_valid = wr_valid;
    assign bus_a.in_wr_hdr = wr_hdr;   assign bus_b.in_wr_hdr = wr_hdr;
    assign bus_a.in_wr_data = wr_data; assign bus_b.in_wr_data = wr_data;
    assign bus_a.rd_rsp_done = rsp_done; assign bus_b.rd_rsp_done = rsp_done;
    assign bus_a.cor_tx_rd_ready = rd_dn; assign bus_b.cor_tx_rd_ready = rd_dn;
    assign bus_a.cor_tx_wr_ready = wr_dn; assign bus_b.cor_tx_wr_ready = wr_dn;

    fthread_tx_arbiter #(.NUM_REQ(N), .MAX_RD_OUTST(16)) dut_a (.clk(clk), .rst_n(rst_n), .tx_if(bus_a));
    fthread_tx_arbiter #(.NUM_REQ(N), .MAX_RD_OUTST(2))  dut_b (.clk(clk), .rst_n(rst_n), .tx_if(bus_b));

    // Behavioural model state per instance.
    int                  maxv [2] = '{16, 2};
    logic                m_rv [2], m_wv [2];
    logic [RD_HDR_W-1:0] m_rh [2];
    logic [WR_HDR_W-1:0] m_wh [2];
    logic [DATA_W-1:0]   m_wd [2];
    int                  m_rid [2], m_rp [2], m_wp [2];
    int                  m_out [2][N];

    logic [N-1:0] acc_rd, acc_wr, seen_rd_a, seen_wr_a, seen_rd_b;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] elig, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (elig[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int idx1h(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [RD_HDR_W-1:0] rnd_rh();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[RD_HDR_W-1:0];
    endfunction

    function automatic logic [WR_HDR_W-1:0] rnd_wh();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[WR_HDR_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] rnd_d();
        logic [DATA_W-1:0] t;
        for (int w = 0; w < DATA_W / 32; w++) t[32*w +: 32] = $urandom;
        return t;
    endfunction

    // One clock: check combinational readies, advance model, check registered outputs.
    task automatic cycle();
        #1;
        for (int u = 0; u < 2; u++) begin
            logic [N-1:0] rel, wel, erd, ewr, drd, dwr;
            int gr, gw;
            bit rl, wl;
            for (int i = 0; i < N; i++) begin
                rel[i] = rd_valid[i] & req_en[i] & (m_out[u][i] < maxv[u]);
                wel[i] = wr_valid[i] & req_en[i];
            end
            rl = !m_rv[u] || rd_dn;
            wl = !m_wv[u] || wr_dn;
            gr = pick(rel, m_rp[u]);
            gw = pick(wel, m_wp[u]);
            erd = '0;
            ewr = '0;
            if (rst_n && rl && gr >= 0) erd[gr] = 1'b1;
            if (rst_n && wl && gw >= 0) ewr[gw] = 1'b1;
            drd = (u == 0) ? bus_a.in_rd_ready : bus_b.in_rd_ready;
            dwr = (u == 0) ? bus_a.in_wr_ready : bus_b.in_wr_ready;
            chk($sformatf("u%0d_in_rd_ready", u), DATA_W'(drd), DATA_W'(erd));
            chk($sformatf("u%0d_in_wr_ready", u), DATA_W'(dwr), DATA_W'(ewr));
            if (u == 0) begin
                acc_rd = erd; acc_wr = ewr; seen_rd_a = drd; seen_wr_a = dwr;
            end else begin
                seen_rd_b = drd;
            end
            if (!rst_n) begin
                m_rv[u] = 1'b0; m_wv[u] = 1'b0; m_rh[u] = '0; m_wh[u] = '0; m_wd[u] = '0;
                m_rid[u] = 0; m_rp[u] = 0; m_wp[u] = 0;
                for (int i = 0; i < N; i++) m_out[u][i] = 0;
            end else begin
                for (int i = 0; i < N; i++)
                    m_out[u][i] = m_out[u][i] + int'(erd[i]) - int'(rsp_done[i] && m_out[u][i] > 0);
                if (rl) begin
                    m_rv[u] = (gr >= 0);
                    if (gr >= 0) begin
                        m_rh[u] = rd_hdr[RD_HDR_W*gr +: RD_HDR_W];
                        m_rid[u] = gr;
                        m_rp[u] = (gr + 1) % N;
                    end
                end
                if (wl) begin
                    m_wv[u] = (gw >= 0);
                    if (gw >= 0) begin
                        m_wh[u] = wr_hdr[WR_HDR_W*gw +: WR_HDR_W];
                        m_wd[u] = wr_data[DATA_W*gw +: DATA_W];
                        m_wp[u] = (gw + 1) % N;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            logic [31:0] eo, dout;
            for (int i = 0; i < N; i++) eo[8*i +: 8] = 8'(m_out[u][i]);
            dout = (u == 0) ? bus_a.rd_outst : bus_b.rd_outst;
            chk($sformatf("u%0d_rd_outst", u), DATA_W'(dout), DATA_W'(eo));
            chk($sformatf("u%0d_rd_valid", u),
                DATA_W'((u == 0) ? bus_a.cor_tx_rd_valid : bus_b.cor_tx_rd_valid), DATA_W'(m_rv[u]));
            chk($sformatf("u%0d_wr_valid", u),
                DATA_W'((u == 0) ? bus_a.cor_tx_wr_valid : bus_b.cor_tx_wr_valid), DATA_W'(m_wv[u]));
            if (m_rv[u]) begin
                chk($sformatf("u%0d_rd_hdr", u),
                    DATA_W'((u == 0) ? bus_a.cor_tx_rd_hdr : bus_b.cor_tx_rd_hdr), DATA_W'(m_rh[u]));
                chk($sformatf("u%0d_rd_id", u),
                    DATA_W'((u == 0) ? bus_a.cor_tx_rd_id : bus_b.cor_tx_rd_id), DATA_W'(m_rid[u]));
            end
            if (m_wv[u]) begin
                chk($sformatf("u%0d_wr_hdr", u),
                    DATA_W'((u == 0) ? bus_a.cor_tx_wr_hdr : bus_b.cor_tx_wr_hdr), DATA_W'(m_wh[u]));
                chk($sformatf("u%0d_wr_data", u),
                    (u == 0) ? bus_a.cor_tx_data : bus_b.cor_tx_data, m_wd[u]);
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_en = '1; rd_valid = '0; wr_valid = '0; rsp_done = '0;
        rd_dn = 1'b1; wr_dn = 1'b1;
        for (int i = 0; i < N; i++) begin
            rd_hdr[RD_HDR_W*i +: RD_HDR_W] = rnd_rh();
            wr_hdr[WR_HDR_W*i +: WR_HDR_W] = rnd_wh();
            wr_data[DATA_W*i +: DATA_W] = rnd_d();
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        cycle();
        chk("rst_rd_valid", DATA_W'(bus_a.cor_tx_rd_valid), '0);
        chk("rst_wr_data", bus_a.cor_tx_data, '0);
        chk("rst_outst", DATA_W'(bus_b.rd_outst), '0);
        rst_n = 1'b1;
    endtask

    // Refresh payload of accepted requesters so every beat is distinct.
    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            if (acc_rd[i]) rd_hdr[RD_HDR_W*i +: RD_HDR_W] = rnd_rh();
            if (acc_wr[i]) begin
                wr_hdr[WR_HDR_W*i +: WR_HDR_W] = rnd_wh();
                wr_data[DATA_W*i +: DATA_W] = rnd_d();
            end
        end
    endtask

    initial begin
        logic [RD_HDR_W-1:0] hv [3];
        logic [RD_HDR_W-1:0] h0;
        int ord_rd [$];
        int ord_wr [$];
        int exp8 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp3 [3] = '{1, 2, 3};
        int exp6 [6] = '{1, 2, 3, 1, 2, 3};

        for (int u = 0; u < 2; u++) begin
            m_rv[u] = 1'b0; m_wv[u] = 1'b0; m_rh[u] = '0; m_wh[u] = '0; m_wd[u] = '0;
        end
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);

        // Requester 2 issues three back-to-back reads.
        do_reset();
        hv[0] = 71'h12_3456_789A_BCDE_F012;
        hv[1] = 71'h55_AAAA_5555_0000_FFFF;
        hv[2] = 71'h7F_0001_0203_0405_0607;
        rd_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            rd_hdr[RD_HDR_W*2 +: RD_HDR_W] = hv[k];
            cycle();
            chk($sformatf("t1_valid%0d", k), DATA_W'(bus_a.cor_tx_rd_valid), DATA_W'(1'b1));
            chk($sformatf("t1_hdr%0d", k), DATA_W'(bus_a.cor_tx_rd_hdr), DATA_W'(hv[k]));
            chk($sformatf("t1_id%0d", k), DATA_W'(bus_a.cor_tx_rd_id), DATA_W'(2'd2));
        end
        rd_valid = '0;
        cycle();
        chk("t1_outst2", DATA_W'(bus_a.rd_outst[23:16]), DATA_W'(8'd3));

        // All four requesters stream writes.
        do_reset();
        wr_valid = 4'b1111;
        ord_wr.delete();
        for (int k = 0; k < 8; k++) begin
            cycle();
            ord_wr.push_back(idx1h(seen_wr_a));
            refresh();
        end
        for (int k = 0; k < 8; k++) chk($sformatf("t2_order%0d", k), DATA_W'(ord_wr[k]), DATA_W'(exp8[k]));
        wr_valid = '0;
        cycle();

        // Downstream stall with requesters pending.
        do_reset();
        rd_valid = 4'b1111;
        h0 = rd_hdr[RD_HDR_W-1:0];
        cycle();
        rd_valid[0] = 1'b0;
        rd_dn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk($sformatf("t3_stall_rdy%0d", k), DATA_W'(seen_rd_a), '0);
            chk($sformatf("t3_stall_hdr%0d", k), DATA_W'(bus_a.cor_tx_rd_hdr), DATA_W'(h0));
        end
        rd_dn = 1'b1;
        ord_rd.delete();
        for (int k = 0; k < 3; k++) begin
            cycle();
            ord_rd.push_back(idx1h(seen_rd_a));
            rd_valid = rd_valid & ~acc_rd;
        end
        for (int k = 0; k < 3; k++) chk($sformatf("t3_order%0d", k), DATA_W'(ord_rd[k]), DATA_W'(exp3[k]));
        cycle();

        // Credit limit (instance b, limit 2).
        do_reset();
        rd_valid = 4'b0010;
        cycle();
        chk("t4_a", DATA_W'(seen_rd_b), DATA_W'(4'b0010));
        cycle();
        chk("t4_b", DATA_W'(seen_rd_b), DATA_W'(4'b0010));
        rd_valid = 4'b1010;
        cycle();
        chk("t4_blocked", DATA_W'(seen_rd_b), DATA_W'(4'b1000));
        rd_valid = 4'b0010;
        rsp_done = 4'b0010;
        cycle();
        chk("t4_done_cycle", DATA_W'(seen_rd_b), '0);
        rsp_done = '0;
        cycle();
        chk("t4_regrant", DATA_W'(seen_rd_b), DATA_W'(4'b0010));
        chk("t4_outst1", DATA_W'(bus_b.rd_outst[15:8]), DATA_W'(8'd2));
        rd_valid = '0;

        // Accept and return together; return at zero.
        do_reset();
        rd_valid = 4'b0001;
        cycle();
        rsp_done = 4'b0001;
        cycle();
        chk("t5_same_cycle", DATA_W'(bus_a.rd_outst[7:0]), DATA_W'(8'd1));
        rd_valid = '0;
        cycle();
        chk("t5_to_zero", DATA_W'(bus_a.rd_outst[7:0]), DATA_W'(8'd0));
        cycle();
        chk("t5_sat_zero", DATA_W'(bus_a.rd_outst[7:0]), DATA_W'(8'd0));
        rsp_done = '0;

        // Requester 0 disabled; then reset mid-burst.
        do_reset();
        req_en = 4'b1110;
        rd_valid = 4'b1111;
        wr_valid = 4'b1111;
        ord_rd.delete();
        ord_wr.delete();
        for (int k = 0; k < 6; k++) begin
            cycle();
            ord_rd.push_back(idx1h(seen_rd_a));
            ord_wr.push_back(idx1h(seen_wr_a));
            refresh();
        end
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t6_rd_order%0d", k), DATA_W'(ord_rd[k]), DATA_W'(exp6[k]));
            chk($sformatf("t6_wr_order%0d", k), DATA_W'(ord_wr[k]), DATA_W'(exp6[k]));
        end
        rst_n = 1'b0;
        cycle();
        chk("t6_rst_rdy", DATA_W'(seen_rd_a), '0);
        chk("t6_rst_rdv", DATA_W'(bus_a.cor_tx_rd_valid), '0);
        chk("t6_rst_wrv", DATA_W'(bus_a.cor_tx_wr_valid), '0);
        chk("t6_rst_outst", DATA_W'(bus_a.rd_outst), '0);
        rst_n = 1'b1;

        // Randomized traffic; requesters hold until accepted by instance a.
        clear_inputs();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 19) == 0) req_en = 4'($urandom);
            rd_dn = ($urandom_range(0, 3) != 0);
            wr_dn = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                rsp_done[i] = ($urandom_range(0, 2) == 0) && m_out[0][i] > 0 && m_out[1][i] > 0;
            cycle();
            for (int i = 0; i < N; i++) begin
                if (acc_rd[i] || !rd_valid[i]) begin
                    rd_valid[i] = 1'($urandom_range(0, 1));
                    rd_hdr[RD_HDR_W*i +: RD_HDR_W] = rnd_rh();
                end
                if (acc_wr[i] || !wr_valid[i]) begin
                    wr_valid[i] = 1'($urandom_range(0, 1));
                    wr_hdr[WR_HDR_W*i +: WR_HDR_W] = rnd_wh();
                    wr_data[DATA_W*i +: DATA_W] = rnd_d();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
